// File: rtl/traffic_light_pkg.sv
// Light colour encoding shared by traffic_light and its downstream consumers; 2'b11 is never legal.
package traffic_light_pkg;
    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } traffic_light_t;
endpackage

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK/DON'T-WALK lamp controller; all outputs registered, one cycle behind their cause.
// Build macro PED_CHIRP_EN enables the audible chirp on WALK entry and on every WALK tick.
module ped_signal_ctrl
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int WALK_TICKS  = 7,
    parameter int FLASH_TICKS = 5
) (
    input  logic                             clk,
    input  logic                             asyn_reset,
    input  traffic_light_t                   light_state,
    input  logic                             ped_button,
    output logic                             ped_request,
    output logic                             walk,
    output logic                             dont_walk,
    output logic [$clog2(FLASH_TICKS+1)-1:0] countdown,
    output logic                             abort,
    output logic                             fault,
    output logic                             chirp
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(WALK_TICKS + 1);
    localparam int CW = $clog2(FLASH_TICKS + 1);

    typedef enum logic [1:0] {
        S_DONT_WALK,
        S_WALK,
        S_FLASH,
        S_FAULT
    } state_t;

    state_t         r_state;
    traffic_light_t r_prev_light;
    logic           r_btn_q;
    logic [PW-1:0]  r_presc;
    logic [WW-1:0]  r_walk_ticks;

    logic [1:0] w_light;
    logic       w_illegal;
    logic       w_red;
    logic       w_red_edge;
    logic       w_btn_rise;
    logic       w_tick;
    logic       w_walk_entry;

    assign w_light      = light_state;
    assign w_illegal    = (w_light == 2'b11);
    assign w_red        = (light_state == RED);
    assign w_red_edge   = w_red && (r_prev_light != RED);
    assign w_btn_rise   = ped_button && !r_btn_q;
    assign w_tick       = (r_presc == PW'(TICK_DIV - 1));
    assign w_walk_entry = (r_state == S_DONT_WALK) && !w_illegal && w_red_edge && ped_request;

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state      <= S_DONT_WALK;
            r_prev_light <= RED;
            r_btn_q      <= 1'b0;
            r_presc      <= '0;
            r_walk_ticks <= '0;
            ped_request  <= 1'b0;
            walk         <= 1'b0;
            dont_walk    <= 1'b1;
            countdown    <= '0;
            abort        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            r_prev_light <= light_state;
            r_btn_q      <= ped_button;
            abort        <= 1'b0;
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            // Every state entry restarts the prescaler so phases last whole ticks.
            if (r_state != S_FAULT && w_illegal) begin
                r_state     <= S_FAULT;
                fault       <= 1'b1;
                walk        <= 1'b0;
                dont_walk   <= 1'b1;
                countdown   <= '0;
                ped_request <= 1'b0;
                r_presc     <= '0;
            end else begin
                case (r_state)
                    S_DONT_WALK: begin
                        if (w_walk_entry) begin
                            r_state      <= S_WALK;
                            walk         <= 1'b1;
                            dont_walk    <= 1'b0;
                            ped_request  <= 1'b0;
                            r_presc      <= '0;
                            r_walk_ticks <= '0;
                        end else if (w_btn_rise) begin
                            ped_request <= 1'b1;
                        end
                    end
                    S_WALK: begin
                        if (!w_red) begin
                            r_state   <= S_DONT_WALK;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            abort     <= 1'b1;
                            r_presc   <= '0;
                        end else if (w_tick) begin
                            if (r_walk_ticks == WW'(WALK_TICKS - 1)) begin
                                r_state   <= S_FLASH;
                                walk      <= 1'b0;
                                dont_walk <= 1'b1;
                                countdown <= CW'(FLASH_TICKS);
                                r_presc   <= '0;
                            end else begin
                                r_walk_ticks <= r_walk_ticks + 1'b1;
                            end
                        end
                    end
                    S_FLASH: begin
                        if (w_btn_rise) begin
                            ped_request <= 1'b1;
                        end
                        if (!w_red) begin
                            r_state   <= S_DONT_WALK;
                            dont_walk <= 1'b1;
                            countdown <= '0;
                            abort     <= 1'b1;
                            r_presc   <= '0;
                        end else if (w_tick) begin
                            if (countdown > CW'(1)) begin
                                countdown <= countdown - 1'b1;
                                dont_walk <= ~dont_walk;
                            end else begin
                                r_state   <= S_DONT_WALK;
                                dont_walk <= 1'b1;
                                countdown <= '0;
                                r_presc   <= '0;
                            end
                        end
                    end
                    S_FAULT: begin
                        if (w_tick) begin
                            dont_walk <= ~dont_walk;
                        end
                    end
                    default: begin
                        r_state <= S_DONT_WALK;
                    end
                endcase
            end
        end
    end

`ifdef PED_CHIRP_EN
    // Looks one cycle ahead so the pulse lines up with the tick cycle itself.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            chirp <= 1'b0;
        end else if (w_illegal) begin
            chirp <= 1'b0;
        end else if (w_walk_entry) begin
            chirp <= 1'b1;
        end else begin
            chirp <= (r_state == S_WALK) && w_red && (r_presc == PW'(TICK_DIV - 2));
        end
    end
`else
    assign chirp = 1'b0;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: directed scenarios with literal expectations, then random light,
// button and async-reset traffic compared every cycle against a phase/elapsed-time model.
module tb_ped_signal_ctrl;
    import traffic_light_pkg::*;

    localparam int TD = 4;
    localparam int WT = 3;
    localparam int FT = 2;

    logic           clk = 1'b0;
    logic           rst;
    traffic_light_t light_state;
    logic           ped_button;
    logic           ped_request;
    logic           walk;
    logic           dont_walk;
    logic [1:0]     countdown;
    logic           abort;
    logic           fault;
    logic           chirp;

    int checks    = 0;
    int failures  = 0;
    int chirp_cnt = 0;

    // Model: phase 0=DONT_WALK 1=WALK 2=FLASH 3=FAULT, m_el = cycles spent in the phase.
    int         m_phase;
    int         m_el;
    bit         m_req;
    bit         m_abort;
    bit         m_fault;
    bit         m_btnq;
    logic [1:0] m_prev;

    ped_signal_ctrl #(
        .TICK_DIV   (TD),
        .WALK_TICKS (WT),
        .FLASH_TICKS(FT)
    ) dut (
        .clk        (clk),
        .asyn_reset (rst),
        .light_state(light_state),
        .ped_button (ped_button),
        .ped_request(ped_request),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .countdown  (countdown),
        .abort      (abort),
        .fault      (fault),
        .chirp      (chirp)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = 0;
        m_el    = 0;
        m_req   = 0;
        m_abort = 0;
        m_fault = 0;
        m_btnq  = 0;
        m_prev  = 2'b00;
    endtask

    task automatic model_step();
        logic [1:0] l;
        bit         rise;
        int         np;
        int         ne;
        bit         na;
        l    = light_state;
        rise = ped_button && !m_btnq;
        np   = m_phase;
        ne   = (m_el < 100000) ? m_el + 1 : m_el;
        na   = 0;
        if (m_phase != 3 && l == 2'b11) begin
            np      = 3;
            ne      = 0;
            m_req   = 0;
            m_fault = 1;
        end else begin
            case (m_phase)
                0: begin
                    if (l == 2'b00 && m_prev != 2'b00 && m_req) begin
                        np    = 1;
                        ne    = 0;
                        m_req = 0;
                    end else if (rise) begin
                        m_req = 1;
                    end
                end
                1: begin
                    if (l != 2'b00) begin
                        np = 0; ne = 0; na = 1;
                    end else if (m_el == WT * TD - 1) begin
                        np = 2; ne = 0;
                    end
                end
                2: begin
                    if (rise) m_req = 1;
                    if (l != 2'b00) begin
                        np = 0; ne = 0; na = 1;
                    end else if (m_el == FT * TD - 1) begin
                        np = 0; ne = 0;
                    end
                end
                default: ;
            endcase
        end
        m_phase = np;
        m_el    = ne;
        m_abort = na;
        m_prev  = l;
        m_btnq  = ped_button;
    endtask

    function automatic logic [8:0] model_out();
        logic       w;
        logic       dw;
        logic       ch;
        logic [1:0] cd;
        w  = (m_phase == 1);
        cd = 2'd0;
        ch = 1'b0;
        case (m_phase)
            0:       dw = 1'b1;
            1:       dw = 1'b0;
            2: begin
                dw = ((m_el / TD) % 2) == 0;
                cd = 2'(FT - m_el / TD);
            end
            default: dw = ((m_el / TD) % 2) == 0;
        endcase
`ifdef PED_CHIRP_EN
        ch = (m_phase == 1) && (m_el == 0 || (m_el % TD) == TD - 1);
`endif
        return {m_req, w, dw, cd, m_abort, m_fault, ch};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        logic [8:0] act;
        logic [8:0] exp;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        if (!rst) begin
            act = {ped_request, walk, dont_walk, countdown, abort, fault, chirp};
            exp = model_out();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_cmp t=%0t actual(req,walk,dw,cd,abort,fault,chirp)=%b required=%b",
                         $time, act, exp);
            end
            if (chirp) chirp_cnt++;
        end
    endtask

    task automatic step(input logic [1:0] l, input logic b, input int n);
        light_state = traffic_light_t'(l);
        ped_button  = b;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic reset_now(input string nm);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk({nm, "_walk"}, walk, 0);
        chk({nm, "_dont_walk"}, dont_walk, 1);
        chk({nm, "_req"}, ped_request, 0);
        chk({nm, "_countdown"}, countdown, 0);
        chk({nm, "_abort"}, abort, 0);
        chk({nm, "_fault"}, fault, 0);
        chk({nm, "_chirp"}, chirp, 0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic press(input logic [1:0] l);
        step(l, 1'b1, 1);
        step(l, 1'b0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst         = 1'b1;
        light_state = RED;
        ped_button  = 1'b0;
        model_reset();
        cyc();
        cyc();
        chk("reset_dont_walk", dont_walk, 1);
        chk("reset_walk", walk, 0);
        chk("reset_fault", fault, 0);
        rst = 1'b0;

        // Normal walk phase.
        step(GREEN, 1'b0, 3);
        step(GREEN, 1'b1, 2);
        chk("s1_req_latched", ped_request, 1);
        step(GREEN, 1'b0, 2);
        chirp_cnt = 0;
        step(RED, 1'b0, 1);
        chk("s1_walk_entry", walk, 1);
        chk("s1_req_cleared", ped_request, 0);
        chk("s1_dw_in_walk", dont_walk, 0);
        step(RED, 1'b0, 11);
        chk("s1_walk_cycle12", walk, 1);
        step(RED, 1'b0, 1);
        chk("s1_flash1_walk", walk, 0);
        chk("s1_flash1_dw", dont_walk, 1);
        chk("s1_flash1_cd", countdown, 2);
        step(RED, 1'b0, 3);
        chk("s1_flash4_dw", dont_walk, 1);
        step(RED, 1'b0, 1);
        chk("s1_flash5_dw", dont_walk, 0);
        chk("s1_flash5_cd", countdown, 1);
        step(RED, 1'b0, 3);
        chk("s1_flash8_dw", dont_walk, 0);
        step(RED, 1'b0, 1);
        chk("s1_done_dw", dont_walk, 1);
        chk("s1_done_cd", countdown, 0);
`ifdef PED_CHIRP_EN
        chk("s6_chirp_count", chirp_cnt, 4);
`else
        chk("s6_chirp_count", chirp_cnt, 0);
`endif

        // No request.
        step(GREEN, 1'b0, 3);
        step(RED, 1'b0, 20);
        chk("s2_walk", walk, 0);
        chk("s2_dw", dont_walk, 1);

        // Unsafe change mid-WALK.
        step(GREEN, 1'b0, 2);
        press(GREEN);
        step(RED, 1'b0, 5);
        chk("s3_in_walk", walk, 1);
        step(GREEN, 1'b0, 1);
        chk("s3_walk", walk, 0);
        chk("s3_dw", dont_walk, 1);
        chk("s3_abort", abort, 1);
        chk("s3_req", ped_request, 0);
        step(GREEN, 1'b0, 1);
        chk("s3_abort_gone", abort, 0);

        // Illegal encoding during FLASH.
        press(GREEN);
        step(RED, 1'b0, 14);
        chk("s4_in_flash_cd", countdown, 2);
        step(2'b11, 1'b0, 1);
        chk("s4_fault", fault, 1);
        chk("s4_fault_dw", dont_walk, 1);
        step(2'b11, 1'b0, 3);
        chk("s4_fault_dw4", dont_walk, 1);
        step(2'b11, 1'b0, 1);
        chk("s4_fault_dw5", dont_walk, 0);
        step(RED, 1'b0, 4);
        chk("s4_fault_sticky", fault, 1);
        reset_now("s4_reset");

        // Reset mid-WALK then a full walk.
        step(GREEN, 1'b0, 2);
        press(GREEN);
        step(RED, 1'b0, 3);
        chk("s5_in_walk", walk, 1);
        reset_now("s5_reset");
        step(GREEN, 1'b0, 2);
        press(GREEN);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(RED, 1'b0, 1);
            if (walk) n++;
        end
        chk("s5_walk_len", n, 12);

        // Random traffic.
        for (int s = 0; s < 350; s++) begin
            logic [1:0] l;
            int r;
            int len;
            r = $urandom_range(0, 99);
            if (r < 2)       l = 2'b11;
            else if (r < 55) l = 2'b00;
            else if (r < 80) l = 2'b10;
            else             l = 2'b01;
            len = (l == 2'b00) ? $urandom_range(1, 30) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step(l, ($urandom_range(0, 3) == 0), 1);
            if (fault || $urandom_range(0, 40) == 0) begin
                #($urandom_range(1, 4));
                rst = 1'b1;
                model_reset();
                cyc();
                rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ped_signal_ctrl.md
Name: ped_signal_ctrl

Overview:
- Downstream consumer of the traffic_light state.
- Drives the pedestrian WALK / DON'T-WALK lamps from the current light colour and a latched pedestrian push-button request.
- Grants a walk phase only on entry into RED, and times the walk and flashing phases with a tick prescaler.
- Flags illegal light encodings and unsafe light changes.

Parameters:
- TICK_DIV, 100, clock cycles per timing tick (>=2).
- WALK_TICKS, 7, ticks of steady WALK (>=1).
- FLASH_TICKS, 5, ticks of flashing DON'T-WALK (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- asyn_reset  in  1  asynchronous, active-high reset.
- light_state  in  traffic_light_t (2)  current light colour from traffic_light_pkg; legal values are RED, YELLOW and GREEN, and 2'b11 is illegal.
- ped_button  in  1  raw push-button level; assumed synchronous to clk.
- ped_request  out  1  latched, pending pedestrian request.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DON'T-WALK lamp.
- countdown  out  $clog2(FLASH_TICKS+1)  ticks remaining in FLASH, otherwise 0.
- abort  out  1  one-cycle pulse when a walk phase is cut short.
- fault  out  1  sticky illegal-encoding flag.
- chirp  out  1  audible cue (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset asyn_reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=DONT_WALK, walk=0, dont_walk=1, countdown=0, ped_request=0, abort=0, fault=0, chirp=0. Internal prev_light_q=RED, btn_q=0.
- Asserting reset mid-phase forces the reset values immediately, without waiting for a clock edge.
- Button: btn_q registers ped_button. A rising edge (ped_button=1, btn_q=0) sets ped_request in DONT_WALK and FLASH; edges in WALK and FAULT are ignored.
- RED edge: red_edge = (light_state==RED) && (prev_light_q!=RED). prev_light_q registers light_state every cycle.
- Tick prescaler: counts 0..TICK_DIV-1 and emits tick on count TICK_DIV-1. It is cleared on every state entry, so phase durations are exact.
- State DONT_WALK: walk=0, dont_walk=1.
  - red_edge && ped_request -> WALK on the next edge.
  - ped_request clears on that same edge. A button edge in the same cycle is absorbed (treated as served).
- State WALK: walk=1, dont_walk=0.
  - After WALK_TICKS ticks (exactly WALK_TICKS*TICK_DIV cycles) -> FLASH.
- State FLASH: walk=0.
  - dont_walk=1 on entry and toggles on every tick.
  - countdown loads FLASH_TICKS on entry and decrements on each tick.
  - countdown reaching 0 -> DONT_WALK with dont_walk=1 steady.
- Abort: in WALK or FLASH, light_state!=RED (legal value) -> DONT_WALK next cycle.
  - abort=1 for exactly that one cycle; countdown=0.
  - ped_request is not re-set.
- FAULT:
  - light_state==2'b11 in any state -> FAULT next cycle; this has priority over all other transitions.
  - In FAULT: fault=1, walk=0, dont_walk toggles every tick, ped_request=0.
  - FAULT exits only by reset.
- Arithmetic: all counters saturate and never wrap. countdown never underflows below 0.

Optional Feature:
- Macro: PED_CHIRP_EN.
- Defined: chirp pulses high for one cycle on each tick while in WALK, and on the WALK entry cycle.
- Undefined: the chirp port exists but is tied to 0, and no chirp logic is built.

Test Plan:
Bench parameters: TICK_DIV=4, WALK_TICKS=3, FLASH_TICKS=2.
1. Normal walk phase: press ped_button 2 cycles during GREEN, then drive RED.
   - ped_request=1 two cycles after the press.
   - walk=1 one cycle after RED arrives, held 12 cycles; ped_request=0.
   - FLASH for 8 cycles with dont_walk pattern 1,1,1,1,0,0,0,0 and countdown 2 then 1.
   - Then dont_walk=1 steady and countdown=0.
2. No request: drive RED with no button press -> walk stays 0 and dont_walk stays 1 for the whole RED.
3. Unsafe change: drive GREEN 5 cycles into WALK -> walk=0 and dont_walk=1 next cycle, abort=1 for exactly one cycle, ped_request=0.
4. Illegal encoding: drive light_state=2'b11 during FLASH -> fault=1 next cycle and dont_walk toggles every 4 cycles. Returning to RED keeps fault=1; asserting asyn_reset clears all outputs to their reset values without a clock edge.
5. Reset mid-WALK: assert asyn_reset between clock edges -> walk=0, dont_walk=1 immediately. After release, a new request plus red_edge produces a full 12-cycle WALK.
6. Chirp (with PED_CHIRP_EN defined, same stimulus as scenario 1) -> chirp pulses at WALK entry and at cycles 4, 8 and 12 of WALK (four pulses). Without the macro, chirp stays 0 throughout.
